// File: rtl/video_timing_pkg.sv
// Raster timing constants for the supported video modes, plus helpers shared
// by the timing generator (total derivation, sync polarity, region decode).
package video_timing_pkg;

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  // 640x480@60, 25 MHz pixel clock
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam logic VGA_H_POL  = POL_NEG;
  localparam logic VGA_V_POL  = POL_NEG;
  localparam int VGA_CW       = 12;

  // 1280x720@60, 74.25 MHz pixel clock
  localparam int HD720_H_ACTIVE = 1280;
  localparam int HD720_H_FP     = 110;
  localparam int HD720_H_SYNC   = 40;
  localparam int HD720_H_BP     = 220;
  localparam int HD720_V_ACTIVE = 720;
  localparam int HD720_V_FP     = 5;
  localparam int HD720_V_SYNC   = 5;
  localparam int HD720_V_BP     = 20;
  localparam logic HD720_H_POL  = POL_POS;
  localparam logic HD720_V_POL  = POL_POS;
  localparam int HD720_CW       = 12;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FP,
    REG_SYNC,
    REG_BP
  } region_e;

  function automatic int calc_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic region_e region_of(input int cnt, input int act, input int fp, input int sync);
    if (cnt < act)                 return REG_ACTIVE;
    else if (cnt < act + fp)       return REG_FP;
    else if (cnt < act + fp + sync) return REG_SYNC;
    else                           return REG_BP;
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// N-stage shift line for the {hsync, vsync, de} group; N=0 passes straight
// through, otherwise every stage resets to the idle pattern.
module sync_delay_line #(
  parameter int N = 2,
  parameter int W = 3,
  parameter logic [W-1:0] IDLE = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (N == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_pipe
      logic [W-1:0] r_stage [N];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < N; i++) r_stage[i] <= IDLE;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[N-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: zero-latency pixel coordinates for the pixel source
// and a sync/de group delayed by PIPE_DLY to line up with its read latency.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic H_POL    = VGA_H_POL,
  parameter logic V_POL    = VGA_V_POL,
  parameter int   CW       = VGA_CW,
  parameter int   PIPE_DLY = 2
) (
  input  logic          pix_clk_in,
  input  logic          rst_in,
  input  logic          en_in,
  output logic [CW-1:0] x_out,
  output logic [CW-1:0] y_out,
  output logic          active_out,
  output logic          line_start_out,
  output logic          frame_start_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [2:0] SYNC_IDLE = {~H_POL, ~V_POL, 1'b0};

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIPE_DLY < 0 || CW < 2 || CW > 30 ||
        H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_params
      $error("video_timing_gen: illegal timing parameters");
    end
  endgenerate

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          w_run;
  logic          w_h_wrap;
  region_e       w_h_region;
  region_e       w_v_region;
  logic [2:0]    w_sync_raw;
  logic [2:0]    w_sync_dly;

  // Gating with rst_in lets the coordinate group drop to idle without a clock.
  assign w_run    = en_in & ~rst_in;
  assign w_h_wrap = (r_h_cnt == H_LAST);

  always_ff @(posedge pix_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!en_in) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CW'(1);
    end
  end

  assign w_h_region = region_of(int'(r_h_cnt), H_ACTIVE, H_FP, H_SYNC);
  assign w_v_region = region_of(int'(r_v_cnt), V_ACTIVE, V_FP, V_SYNC);

  assign x_out           = w_run ? r_h_cnt : '0;
  assign y_out           = w_run ? r_v_cnt : '0;
  assign active_out      = w_run && (w_h_region == REG_ACTIVE) && (w_v_region == REG_ACTIVE);
  assign line_start_out  = w_run && (r_h_cnt == '0);
  assign frame_start_out = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);

  // vsync follows v_cnt, which only moves on the h wrap, so it is line-aligned.
  assign w_sync_raw = w_run ? {((w_h_region == REG_SYNC) ? H_POL : ~H_POL),
                               ((w_v_region == REG_SYNC) ? V_POL : ~V_POL),
                               active_out}
                            : SYNC_IDLE;

  sync_delay_line #(
    .N    (PIPE_DLY),
    .W    (3),
    .IDLE (SYNC_IDLE)
  ) u_sync_dly (
    .i_clk (pix_clk_in),
    .i_rst (rst_in),
    .i_d   (w_sync_raw),
    .o_q   (w_sync_dly)
  );

  assign hsync_out = w_sync_dly[2];
  assign vsync_out = w_sync_dly[1];
  assign de_out    = w_sync_dly[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: full-size raster for line timing, enable abort and async
// reset; a reduced raster at PIPE_DLY 0/2/5 for frame and alignment checks.
module tb_video_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        en_s;

  logic [11:0] x, y;
  logic        act, ls, fs, hs, vs, de;

  localparam int SDLY [3] = '{0, 2, 5};
  logic [11:0] sx [3];
  logic [11:0] sy [3];
  logic        sact [3];
  logic        sls [3];
  logic        sfs [3];
  logic        shs [3];
  logic        svs [3];
  logic        sde [3];

  int n_vec = 0;
  int n_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen #(.PIPE_DLY(2)) u_dut (
    .pix_clk_in      (clk),
    .rst_in          (rst),
    .en_in           (en),
    .x_out           (x),
    .y_out           (y),
    .active_out      (act),
    .line_start_out  (ls),
    .frame_start_out (fs),
    .hsync_out       (hs),
    .vsync_out       (vs),
    .de_out          (de)
  );

  // 25 clocks per line, 15 lines per frame: 16 active pixels, 8 active lines.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_small
      video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIPE_DLY(SDLY[gi])
      ) u_small (
        .pix_clk_in      (clk),
        .rst_in          (rst),
        .en_in           (en_s),
        .x_out           (sx[gi]),
        .y_out           (sy[gi]),
        .active_out      (sact[gi]),
        .line_start_out  (sls[gi]),
        .frame_start_out (sfs[gi]),
        .hsync_out       (shs[gi]),
        .vsync_out       (svs[gi]),
        .de_out          (sde[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) begin
      $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic s_act(input int j);
    if (j < 0) return 1'b0;
    return ((j % 25) < 16) && (((j / 25) % 15) < 8);
  endfunction

  initial begin
    int coord_err, sync_err, abort_err;
    int hs_fall, hs_low0, de_cnt0, de_cnt1, ls_second;
    int pipe_err [3];
    int sact_err [3];
    int fs2, vs_low, vs_fall, de_lines;
    logic prev_hs, prev_svs, prev_sde;

    coord_err = 0; sync_err = 0; abort_err = 0;
    hs_fall = -1; hs_low0 = 0; de_cnt0 = 0; de_cnt1 = 0; ls_second = -1;
    fs2 = -1; vs_low = 0; vs_fall = -1; de_lines = 0;
    for (int i = 0; i < 3; i++) begin pipe_err[i] = 0; sact_err[i] = 0; end

    // Reset held with enable high
    rst = 1'b0; en = 1'b1; en_s = 1'b1;
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_x",       32'(x),   0);
    check("rst_y",       32'(y),   0);
    check("rst_active",  32'(act), 0);
    check("rst_line_st", 32'(ls),  0);
    check("rst_frame_st",32'(fs),  0);
    check("rst_hsync",   32'(hs),  1);
    check("rst_vsync",   32'(vs),  1);
    check("rst_de",      32'(de),  0);
    check("rst_s0_hsync",32'(shs[0]), 1);
    check("rst_s0_de",   32'(sde[0]), 0);

    // Release: first enabled cycle is the frame start
    rst = 1'b0;
    #1;
    check("rel_frame_st", 32'(fs),  1);
    check("rel_active",   32'(act), 1);
    prev_hs = hs; prev_svs = svs[1]; prev_sde = 1'b0;

    for (int k = 0; k < 1600; k++) begin
      int ex, ey, j;
      logic exp_de, exp_hs;
      if (k > 0) @(negedge clk);
      ex = k % 800; ey = k / 800; j = k - 2;
      if (x !== 12'(ex) || y !== 12'(ey) || act !== (ex < 640) ||
          ls !== (ex == 0) || fs !== (k == 0)) coord_err++;
      exp_de = (j >= 0) && ((j % 800) < 640);
      exp_hs = !((j >= 0) && ((j % 800) >= 656) && ((j % 800) < 752));
      if (de !== exp_de || hs !== exp_hs || vs !== 1'b1) sync_err++;
      if (prev_hs && !hs && hs_fall < 0) hs_fall = k;
      if (k < 800 && !hs) hs_low0++;
      if (k < 800 && de) de_cnt0++;
      if (k >= 800 && de) de_cnt1++;
      if (k > 0 && ls && ls_second < 0) ls_second = k;
      prev_hs = hs;

      for (int i = 0; i < 3; i++) begin
        if (sde[i] !== s_act(k - SDLY[i])) pipe_err[i]++;
        if (sact[i] !== s_act(k)) sact_err[i]++;
      end
      if (k > 0 && sfs[1] && fs2 < 0) fs2 = k;
      if (k < 375 && !svs[1]) vs_low++;
      if (k < 375 && prev_svs && !svs[1] && vs_fall < 0) vs_fall = k;
      if (k < 375 && sde[1] && !prev_sde) de_lines++;
      prev_svs = svs[1]; prev_sde = sde[1];
    end

    check("line_coords",   32'(coord_err), 0);
    check("line_sync",     32'(sync_err),  0);
    check("hsync_fall",    32'(hs_fall),   658);
    check("hsync_width",   32'(hs_low0),   96);
    check("de_line0",      32'(de_cnt0),   640);
    check("de_line1",      32'(de_cnt1),   640);
    check("line_period",   32'(ls_second), 800);
    check("pipe0_de",      32'(pipe_err[0]), 0);
    check("pipe2_de",      32'(pipe_err[1]), 0);
    check("pipe5_de",      32'(pipe_err[2]), 0);
    check("pipe0_active",  32'(sact_err[0]), 0);
    check("pipe2_active",  32'(sact_err[1]), 0);
    check("pipe5_active",  32'(sact_err[2]), 0);
    check("frame_period",  32'(fs2),       375);
    check("vsync_width",   32'(vs_low),    50);
    check("vsync_start",   32'(vs_fall),   252);
    check("de_lines",      32'(de_lines),  8);

    // Enable abort mid-line at x=300, y=2
    repeat (301) @(negedge clk);
    check("abort_pre_x",  32'(x),  300);
    check("abort_pre_y",  32'(y),  2);
    check("abort_pre_de", 32'(de), 1);
    en = 1'b0;
    #1;
    check("abort_x",      32'(x),   0);
    check("abort_y",      32'(y),   0);
    check("abort_active", 32'(act), 0);
    check("abort_de_d0",  32'(de),  1);
    @(negedge clk);
    check("abort_de_d1",  32'(de),  1);
    @(negedge clk);
    check("abort_de_d2",  32'(de),  0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (x !== 12'd0 || y !== 12'd0 || act !== 1'b0 || ls !== 1'b0 ||
          fs !== 1'b0 || de !== 1'b0 || hs !== 1'b1 || vs !== 1'b1) abort_err++;
    end
    check("abort_idle",   32'(abort_err), 0);
    en = 1'b1;
    #1;
    check("reen_frame_st", 32'(fs),  1);
    check("reen_x",        32'(x),   0);
    check("reen_y",        32'(y),   0);
    check("reen_active",   32'(act), 1);

    // Async reset between edges while hsync is asserted
    repeat (1500) @(negedge clk);
    check("arst_pre_x",  32'(x),  700);
    check("arst_pre_y",  32'(y),  1);
    check("arst_pre_hs", 32'(hs), 0);
    #2 rst = 1'b1;
    #1;
    check("arst_hsync",    32'(hs),  1);
    check("arst_vsync",    32'(vs),  1);
    check("arst_de",       32'(de),  0);
    check("arst_x",        32'(x),   0);
    check("arst_y",        32'(y),   0);
    check("arst_active",   32'(act), 0);
    check("arst_frame_st", 32'(fs),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_frame_st", 32'(fs), 1);
    check("post_x0",       32'(x),  0);
    check("post_y0",       32'(y),  0);
    @(negedge clk);
    check("post_x1",       32'(x),  1);
    check("post_de1",      32'(de), 0);
    @(negedge clk);
    check("post_de2",      32'(de), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the HDMI controller (TMDS encode and serialise stage).
- Produces pixel coordinates for the pixel source, e.g. the snake tile renderer and framebuffer read.
- Produces hsync/vsync/data-enable for the encoder, with the sync group delayed by a fixed count to match pixel-source read latency.
- Runs entirely in the pixel clock domain; default timing is 640x480@60 (25 MHz pixel clock).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- CW, 12, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- PIPE_DLY, 2, cycles the sync group lags the coordinate group; 0 is legal

Ports:
- pix_clk_in  in  1  pixel clock; one clock domain
- rst_in  in  1  asynchronous, active-high reset
- en_in  in  1  run enable
- x_out  out  CW  horizontal counter (0..H_TOTAL-1)
- y_out  out  CW  vertical counter (0..V_TOTAL-1)
- active_out  out  1  (x_out<H_ACTIVE)&&(y_out<V_ACTIVE), same cycle as x/y
- line_start_out  out  1  1-cycle pulse when x_out==0
- frame_start_out  out  1  1-cycle pulse when x_out==0 && y_out==0
- hsync_out  out  1  delayed by PIPE_DLY, polarity H_POL
- vsync_out  out  1  delayed by PIPE_DLY, polarity V_POL
- de_out  out  1  active_out delayed by PIPE_DLY

Behaviour:
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Reset state (async on rst_in high):
  - h_cnt=0, v_cnt=0
  - active_out=0, line_start_out=0, frame_start_out=0, de_out=0
  - hsync_out=~H_POL, vsync_out=~V_POL (inactive levels)
  - delay pipeline filled with the idle pattern
- Horizontal counter: when en_in=1, h_cnt increments every clock. At h_cnt==H_TOTAL-1 it wraps to 0 and v_cnt advances.
- Vertical counter: at v_cnt==V_TOTAL-1 together with an h wrap, v_cnt wraps to 0.
- Horizontal regions by h_cnt:
  - active [0,H_ACTIVE)
  - front porch [H_ACTIVE,H_ACTIVE+H_FP)
  - sync [H_ACTIVE+H_FP,H_ACTIVE+H_FP+H_SYNC)
  - back porch: the remainder
- Vertical regions use the same ranges on v_cnt. vsync changes only on the cycle h_cnt wraps (line-aligned).
- Coordinate group (x/y/active/line_start/frame_start) is derived from the counter registers. No latency relative to the counters.
- Sync group: raw {hsync, vsync, de} are computed from the same counter state, then passed through a PIPE_DLY-stage register shift line. With PIPE_DLY=0 the raw values are output directly.
- en_in=0: on each clock, counters are held cleared to 0 and the idle pattern is shifted into the delay line.
  - Coordinate pulses and active_out are forced to 0 while en_in=0.
  - The sync group reaches idle PIPE_DLY cycles after en_in falls.
- en_in rising: the first cycle with en_in=1 presents x=0, y=0, active_out=1 and frame_start_out=1. Frames always restart cleanly.
- Deasserting en_in mid-line or mid-frame abandons the frame. No partial-line completion.
- rst_in mid-frame: immediate return to the reset state, independent of the clock. After release, behaviour is as if en_in just rose, provided en_in=1.
- Parameter sanity: all porch/sync values must be >=1, and CW must be sufficient; an elaboration-time check fails otherwise.

Decomposition:
- video_timing_pkg holds the timing constants for 640x480@60 and 1280x720@60, H_TOTAL/V_TOTAL derivation and a polarity encoding. Top-level parameters default from it.
- One sub-module, sync_delay_line: a parameterised N-stage shift register with a reset/idle value, width 3. It handles N=0 as pass-through.

Test Plan:
- Reset: hold rst_in=1 for 4 clocks with en_in=1 -> hsync_out=1, vsync_out=1, de_out=0, x_out=0, y_out=0, no pulses.
- Line timing: after reset release, measure from frame_start_out:
  - hsync_out low for exactly 96 consecutive clocks, falling PIPE_DLY+656 clocks after x_out=0
  - line period 800 clocks
  - de_out high for exactly 640 clocks per visible line
- Frame timing: frame_start_out pulses spaced exactly 420000 clocks apart; 480 lines with de activity per frame; vsync_out low for exactly 1600 clocks, starting at line 490.
- Pipeline alignment: sweep PIPE_DLY=0,2,5 -> de_out equals active_out delayed by exactly PIPE_DLY cycles, checked every cycle for one full frame.
- Enable abort: drop en_in at x=300, y=100 for 10 clocks, then raise it -> x/y read 0 while en_in is low, de_out idle PIPE_DLY clocks later, and the first enabled cycle shows frame_start_out=1 with x=0, y=0.
- Async reset mid-frame: assert rst_in between clock edges at y=250 -> outputs reach reset values before the next edge, and counting restarts from 0,0 after release.
